seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
- Time-multiplexed controller that drives an N-digit common-anode 7-segment display from one shared segment bus.
- Holds a packed hex value and scans the digits in a fixed order, one digit per time slot.
- Inserts a blanking interval between digits so the previous digit's segments do not ghost onto the next.
- Applies leading-zero blanking on request.
- Updates the displayed value only at frame boundaries, so no frame ever shows a mix of old and new digits.
- Sits between the system's numeric registers and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be ≥2.
- REFRESH_DIV, 1000: clocks per digit slot; must be > BLANK_CYCLES.
- BLANK_CYCLES, 16: clocks at the start of each slot with all anodes off; must be ≥1.

Ports:
- clk, input, 1: single system clock.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: 1 = scan; 0 = display dark.
- load, input, 1: 1-cycle strobe that captures value and dp_in.
- value, input, 4*NUM_DIGITS: nibble i is digit i; digit 0 is least significant (rightmost).
- dp_in, input, NUM_DIGITS: decimal point per digit, 1 = lit.
- lzb_en, input, 1: enables leading-zero blanking.
- segment, output, 7: {g,f,e,d,c,b,a}, active-low.
- dp, output, 1: decimal point, active-low.
- anode, output, NUM_DIGITS: digit enables, active-low.
- digit_idx, output, clog2(NUM_DIGITS): index of the digit currently being scanned.
- update_pending, output, 1: a loaded value is waiting for the next frame boundary.

Behaviour:
- Reset values: state=IDLE, anode all 1, segment=7'h7F, dp=1, digit_idx=0, slot counter=0, display and pending registers 0, update_pending=0.
- All outputs are registered. Segment, dp and anode change in the same cycle.
- State machine:
  - IDLE: outputs dark. If enable=1, the next state is BLANK with idx=0 and counter=0.
  - BLANK: anodes all 1, segment=7F, dp=1, counter increments. When counter=BLANK_CYCLES-1, go to ON.
  - ON: anode[idx]=0, other anodes 1, segment and dp driven for digit idx. When counter=REFRESH_DIV-1, counter←0, idx←(idx+1) mod NUM_DIGITS, go to BLANK.
  - Any state with enable=0: the next cycle is IDLE, outputs dark, idx=0, counter=0. Pending data is retained.
- Frame boundary: the ON→BLANK transition where idx wraps from NUM_DIGITS-1 to 0.
  - At the boundary, the display register ← pending data, and update_pending is cleared.
- load behaviour:
  - load in IDLE: the display register updates on the next clock; update_pending stays 0.
  - load in BLANK/ON: pending ← {value, dp_in}; update_pending=1 on the next cycle.
  - Repeated loads before the boundary: the last one wins.
  - load in the same cycle as a boundary: the new data goes directly to the display register, and update_pending=0.
- Decode, active-low, {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking (lzb_en=1):
  - Digit i (for i>0) is blanked if it and every higher digit are 0. Digit 0 is never blanked.
  - A blanked digit has segment=7F. Its anode is still asserted in its slot, and dp follows dp_in of the display register.
  - lzb_en is sampled live, not shadowed.
- Scan period: NUM_DIGITS*REFRESH_DIV clocks. Each digit is lit for REFRESH_DIV-BLANK_CYCLES clocks.
- Counter width: clog2(REFRESH_DIV). There is no overflow, because the counter always resets at REFRESH_DIV-1.
- Reset asserted mid-operation: all outputs return to their reset values immediately, independent of clk.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset, then enable=1, then load value=16'h1234 while idle:
  - 2 cycles all-dark per slot, then 6 cycles per digit.
  - anode=1110 with segment=0011001 (4); then 1101 with 0110000 (3); then 1011 with 0100100 (2); then 0111 with 1111001 (1); then repeat. Period 32 clocks.
- Mid-frame load of 16'hABCD while 16'h1234 is displayed:
  - update_pending=1 on the next cycle.
  - The remaining digits of this frame still show 1234.
  - From the boundary on, slot 0 shows d=0100001, and update_pending drops.
- lzb_en=1, value=16'h0005, dp_in=4'b0100:
  - Digits 3 and 1 show 7F with dp=1.
  - Digit 2 shows 7F with dp=0.
  - Digit 0 shows 0010010.
  - With value=0, digit 0 shows 1000000.
- enable deasserted during the ON slot of digit 2:
  - The next cycle is dark and digit_idx=0.
  - Re-enable: scanning restarts at a BLANK of digit 0.
- Two loads (16'h1111, then 16'h2222) within one frame, plus a load asserted exactly at a boundary cycle:
  - Only 2222 appears after the boundary.
  - The boundary-cycle load shows from slot 0 with no extra frame of delay.
- reset pulled low mid-ON:
  - Asynchronously: anode=1111, segment=7F, dp=1, digit_idx=0.
  - The display register clears, so after re-enable 0000 is shown.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Scans digits with a blanking gap per slot; new values take effect only at frame boundaries.
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          lzb_en,
  output logic [6:0]                    segment,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          update_pending
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t                  state_reg, state_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [4*NUM_DIGITS-1:0] disp_val_reg, disp_val_next;
  logic [NUM_DIGITS-1:0]   disp_dp_reg, disp_dp_next;
  logic [4*NUM_DIGITS-1:0] pend_val_reg, pend_val_next;
  logic [NUM_DIGITS-1:0]   pend_dp_reg, pend_dp_next;
  logic                    pending_reg, pending_next;
  logic                    boundary;
  logic [6:0]              segment_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   anode_next;
  logic [NUM_DIGITS-1:0]   zero_above;
  logic [3:0]              nib [NUM_DIGITS];

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  // zero_above[i]: digit i and every higher digit of the next display value are zero
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi]        = disp_val_next[4*gi +: 4];
      assign zero_above[gi] = (disp_val_next[4*NUM_DIGITS-1:4*gi] == '0);
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    cnt_next      = cnt_reg;
    disp_val_next = disp_val_reg;
    disp_dp_next  = disp_dp_reg;
    pend_val_next = pend_val_reg;
    pend_dp_next  = pend_dp_reg;
    pending_next  = pending_reg;
    boundary      = 1'b0;

    if (!enable) begin
      state_next = IDLE;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = BLANK;
          idx_next   = '0;
          cnt_next   = '0;
        end
        BLANK: begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == BLANK_LAST) state_next = ON;
        end
        ON: begin
          if (cnt_reg == SLOT_LAST) begin
            cnt_next   = '0;
            state_next = BLANK;
            if (idx_reg == IDX_LAST) begin
              idx_next = '0;
              boundary = 1'b1;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (boundary && pending_reg) begin
      disp_val_next = pend_val_reg;
      disp_dp_next  = pend_dp_reg;
      pending_next  = 1'b0;
    end

    // A load while dark or on the boundary itself can never tear a frame, so it goes straight in
    if (load) begin
      if (state_reg == IDLE || boundary) begin
        disp_val_next = value;
        disp_dp_next  = dp_in;
        pending_next  = 1'b0;
      end else begin
        pend_val_next = value;
        pend_dp_next  = dp_in;
        pending_next  = 1'b1;
      end
    end
  end

  always_comb begin
    segment_next = 7'h7F;
    dp_next      = 1'b1;
    anode_next   = '1;
    if (state_next == ON) begin
      anode_next[idx_next] = 1'b0;
      dp_next              = ~disp_dp_next[idx_next];
      if (!(lzb_en && idx_next != '0 && zero_above[idx_next]))
        segment_next = decode(nib[idx_next]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      disp_val_reg   <= '0;
      disp_dp_reg    <= '0;
      pend_val_reg   <= '0;
      pend_dp_reg    <= '0;
      pending_reg    <= 1'b0;
      segment        <= 7'h7F;
      dp             <= 1'b1;
      anode          <= '1;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      disp_val_reg   <= disp_val_next;
      disp_dp_reg    <= disp_dp_next;
      pend_val_reg   <= pend_val_next;
      pend_dp_reg    <= pend_dp_next;
      pending_reg    <= pending_next;
      segment        <= segment_next;
      dp             <= dp_next;
      anode          <= anode_next;
    end
  end

  assign digit_idx      = idx_reg;
  assign update_pending = pending_reg;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: directed scenarios then random traffic,
// checked every cycle against a time-based model of the scan.
module tb_seven_segment_scanner;
  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        lzb_en = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  segment;
  logic        dp;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        update_pending;

  int checks = 0;
  int errors = 0;

  // Model: while scanning, t counts clocks since the first BLANK cycle of digit 0
  bit          running;
  int unsigned t;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, p_dp;
  bit          p_flag;
  logic [6:0]  seg_tab [16];

  always #5 clk = ~clk;

  seven_segment_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .lzb_en(lzb_en), .segment(segment), .dp(dp), .anode(anode),
    .digit_idx(digit_idx), .update_pending(update_pending)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    running = 0; t = 0; m_val = '0; m_dp = '0; p_val = '0; p_dp = '0; p_flag = 0;
  endtask

  task automatic model_step();
    bit bnd;
    bnd = running && enable && (t % (N*R) == N*R - 1);
    if (load) begin
      if (!running || bnd) begin m_val = value; m_dp = dp_in; p_flag = 0; end
      else begin p_val = value; p_dp = dp_in; p_flag = 1; end
    end else if (bnd && p_flag) begin
      m_val = p_val; m_dp = p_dp; p_flag = 0;
    end
    if (!enable) begin running = 0; t = 0; end
    else if (!running) begin running = 1; t = 0; end
    else t++;
  endtask

  task automatic check_all();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [1:0] e_idx;
    logic [3:0] nb;
    int d, ph;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 2'd0;
    if (running) begin
      d = int'((t / R) % N);
      ph = int'(t % R);
      e_idx = d[1:0];
      if (ph >= B) begin
        e_an = ~(4'b0001 << d);
        e_dp = ~m_dp[d];
        nb = m_val[4*d +: 4];
        if (!(lzb_en && d > 0 && (m_val >> (4*d)) == 16'h0)) e_seg = seg_tab[nb];
      end
    end
    chk("anode", 16'(anode), 16'(e_an));
    chk("segment", 16'(segment), 16'(e_seg));
    chk("dp", 16'(dp), 16'(e_dp));
    chk("digit_idx", 16'(digit_idx), 16'(e_idx));
    chk("update_pending", 16'(update_pending), 16'(p_flag));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset(); else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Advance until the model is in the lit part of slot `dig` (dig<0: any digit)
  task automatic wait_lit(input int dig);
    int n;
    n = 0;
    while (!(running && int'(t % R) >= B && (dig < 0 || int'((t / R) % N) == dig)) && n < 200) begin
      tick(); n++;
    end
    chk("wait_lit_bound", 16'(n < 200), 16'd1);
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b1;

    // 1234 loaded while idle, then scanned
    do_load(16'h1234, 4'b0000);
    enable = 1'b1;
    ticks(40);
    wait_lit(1);

    // mid-frame load must wait for the boundary
    do_load(16'hABCD, 4'b0001);
    ticks(70);

    // leading-zero blanking
    lzb_en = 1'b1;
    do_load(16'h0005, 4'b0100);
    ticks(70);
    do_load(16'h0000, 4'b0000);
    ticks(70);
    lzb_en = 1'b0;

    // disable during digit 2 lit slot, then re-enable
    wait_lit(2);
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    ticks(20);

    // two loads in one frame, then one exactly at a boundary
    wait_lit(0);
    do_load(16'h1111, 4'b0000);
    ticks(3);
    do_load(16'h2222, 4'b0000);
    ticks(40);
    begin
      int n;
      n = 0;
      while (!(running && t % (N*R) == N*R - 1) && n < 100) begin tick(); n++; end
      chk("boundary_bound", 16'(n < 100), 16'd1);
    end
    do_load(16'h3333, 4'b1000);
    ticks(40);

    // async reset mid-ON
    wait_lit(-1);
    reset = 1'b0;
    #1;
    chk("async_anode", 16'(anode), 16'h000F);
    chk("async_segment", 16'(segment), 16'h007F);
    chk("async_dp", 16'(dp), 16'h0001);
    chk("async_digit_idx", 16'(digit_idx), 16'h0000);
    chk("async_pending", 16'(update_pending), 16'h0000);
    model_reset();
    tick();
    reset = 1'b1;
    ticks(40);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 39) != 0);
      load   = ($urandom_range(0, 7) == 0);
      value  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
      dp_in  = 4'($urandom);
      if ($urandom_range(0, 99) == 0) lzb_en = ~lzb_en;
      tick();
      load = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
